frame_pattern_writer: RTL and testbench



---
 rtl/frame_pattern_writer.sv | 144 ++++++++++++++
 tb/tb_frame_pattern_writer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pattern_writer.sv
// rtl/frame_pattern_writer.sv - synthetic test-pattern source driving the frame buffer write port
module frame_pattern_writer #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int ADDR_WIDTH = 15,
    parameter int PIX_WIDTH  = 1,
    parameter int BOX_X0     = 41,
    parameter int BOX_X1     = 118,
    parameter int BOX_Y0     = 31,
    parameter int BOX_Y1     = 88,
    parameter int CHECK_LOG2 = 3
) (
    input  logic                  clk_25,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic                  continuous,
    input  logic [PIX_WIDTH-1:0]  fg,
    input  logic [PIX_WIDTH-1:0]  bg,
    input  logic                  wr_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [PIX_WIDTH-1:0]  pixel,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            frame_count
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [XW-1:0]        x_next;
    logic [YW-1:0]        y_next;
    logic                 last_pixel;
    logic [2:0]           mode_q;
    logic [PIX_WIDTH-1:0] fg_q;
    logic [PIX_WIDTH-1:0] bg_q;

    // Pixel value for a coordinate; widened to int so parameter compares and
    // cell-bit selects stay legal even when CHECK_LOG2 exceeds the counter width.
    function automatic logic [PIX_WIDTH-1:0] pattern(
        input logic [XW-1:0]        px,
        input logic [YW-1:0]        py,
        input logic [2:0]           pm,
        input logic [PIX_WIDTH-1:0] pfg,
        input logic [PIX_WIDTH-1:0] pbg
    );
        int   xi;
        int   yi;
        logic hit;
        xi = int'(px);
        yi = int'(py);
        case (pm)
            3'd1:    hit = (xi >= BOX_X0) && (xi <= BOX_X1) && (yi >= BOX_Y0) && (yi <= BOX_Y1);
            3'd2:    hit = xi[CHECK_LOG2] ^ yi[CHECK_LOG2];
            3'd3:    hit = xi[CHECK_LOG2];
            3'd4:    hit = (xi == 0) || (xi == H_RES - 1) || (yi == 0) || (yi == V_RES - 1);
            default: hit = 1'b1;
        endcase
        return hit ? pfg : pbg;
    endfunction

    // Raster-order successor of the current coordinate and end-of-frame detect
    always_comb begin
        x_next     = x + XW'(1);
        y_next     = y;
        last_pixel = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));
        if (x == XW'(H_RES - 1)) begin
            x_next = '0;
            y_next = y + YW'(1);
        end
    end

    // Frame sequencer: latches config at frame start, advances on each accepted write
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            mode_q      <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            we          <= 1'b0;
            write_addr  <= '0;
            pixel       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    we   <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        mode_q     <= mode;
                        fg_q       <= fg;
                        bg_q       <= bg;
                        x          <= '0;
                        y          <= '0;
                        write_addr <= '0;
                        pixel      <= pattern('0, '0, mode, fg, bg);
                        we         <= 1'b1;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (wr_ready) begin
                        if (last_pixel) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                            x           <= '0;
                            y           <= '0;
                            write_addr  <= '0;
                            if (continuous) begin
                                mode_q <= mode;
                                fg_q   <= fg;
                                bg_q   <= bg;
                                pixel  <= pattern('0, '0, mode, fg, bg);
                            end else begin
                                we    <= 1'b0;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            x          <= x_next;
                            y          <= y_next;
                            write_addr <= write_addr + ADDR_WIDTH'(1);
                            pixel      <= pattern(x_next, y_next, mode_q, fg_q, bg_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pattern_writer.sv
// tb/tb_frame_pattern_writer.sv - directed self-checking bench for frame_pattern_writer
module tb_frame_pattern_writer;

    logic        clk_25 = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  mode;
    logic        continuous;
    logic        fg;
    logic        bg;
    logic        wr_ready;
    logic        we;
    logic [14:0] write_addr;
    logic        pixel;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_count;

    logic        s_start;
    logic        s_ready;
    logic        s_we;
    logic [3:0]  s_addr;
    logic        s_pixel;
    logic        s_busy;
    logic        s_done;
    logic [7:0]  s_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic pix_seen [0:32767];
    int   accepted;
    int   order_err;
    int   stall_err;
    int   done_cnt;

    always #20 clk_25 = ~clk_25;

    frame_pattern_writer u_dut (
        .clk_25      (clk_25),
        .reset_n     (reset_n),
        .start       (start),
        .mode        (mode),
        .continuous  (continuous),
        .fg          (fg),
        .bg          (bg),
        .wr_ready    (wr_ready),
        .we          (we),
        .write_addr  (write_addr),
        .pixel       (pixel),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    frame_pattern_writer #(
        .H_RES      (4),
        .V_RES      (3),
        .ADDR_WIDTH (4)
    ) u_small (
        .clk_25      (clk_25),
        .reset_n     (reset_n),
        .start       (s_start),
        .mode        (mode),
        .continuous  (continuous),
        .fg          (fg),
        .bg          (bg),
        .wr_ready    (s_ready),
        .we          (s_we),
        .write_addr  (s_addr),
        .pixel       (s_pixel),
        .busy        (s_busy),
        .frame_done  (s_done),
        .frame_count (s_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Box reference with fg=0, bg=1: inside the box reads 0
    function automatic logic box_ref(input int xx, input int yy);
        return (xx >= 41 && xx <= 118 && yy >= 31 && yy <= 88) ? 1'b0 : 1'b1;
    endfunction

    function automatic int box_mismatches();
        int n;
        n = 0;
        for (int a = 0; a < 19200; a++)
            if (pix_seen[a] !== box_ref(a % 160, a / 160)) n++;
        return n;
    endfunction

    // Collect accepted writes; random stalls only within stall_edge accepts of either frame end.
    // Stops on frame_done, or when write_addr reaches stop_addr (if >= 0).
    task automatic capture(input int stall_edge, input int budget, input int stop_addr);
        logic        prev_stall;
        logic [14:0] pa;
        logic        pp;
        accepted   = 0;
        order_err  = 0;
        stall_err  = 0;
        done_cnt   = 0;
        prev_stall = 1'b0;
        pa         = '0;
        pp         = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (accepted < stall_edge || accepted >= 19200 - stall_edge)
                wr_ready = ($urandom_range(1) == 1);
            else
                wr_ready = 1'b1;
            if (prev_stall && (we !== 1'b1 || write_addr !== pa || pixel !== pp)) stall_err++;
            if (frame_done) begin
                done_cnt++;
                break;
            end
            if (stop_addr >= 0 && int'(write_addr) == stop_addr) break;
            if (we && wr_ready) begin
                if (int'(write_addr) != accepted) order_err++;
                pix_seen[write_addr] = pixel;
                accepted++;
            end
            prev_stall = we && !wr_ready;
            pa         = write_addr;
            pp         = pixel;
            tick();
        end
        wr_ready = 1'b1;
    endtask

    initial begin
        int          idx;
        int          frame;
        int          bad1;
        int          fgcnt;
        int          last_acc;
        int          s_acc;
        logic        s_seen;
        logic [11:0] mask;

        reset_n = 1'b0; start = 1'b0; mode = 3'd0; continuous = 1'b0;
        fg = 1'b0; bg = 1'b0; wr_ready = 1'b1; s_start = 1'b0; s_ready = 1'b1;
        repeat (3) tick();
        check("rst_we", we, 0);
        check("rst_addr", write_addr, 0);
        check("rst_pixel", pixel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_count", frame_count, 0);
        reset_n = 1'b1;
        tick();

        // Single box frame, no back-pressure
        mode = 3'd1; fg = 1'b0; bg = 1'b1;
        start_frame();
        check("s1_first_we", we, 1);
        check("s1_first_addr", write_addr, 0);
        check("s1_first_busy", busy, 1);
        check("s1_first_pixel", pixel, 1);
        capture(0, 25000, -1);
        check("s1_accepted", accepted, 19200);
        check("s1_order", order_err, 0);
        check("s1_pix0", pix_seen[0], 1);
        check("s1_pix5001", pix_seen[5001], 0);
        check("s1_pix14358", pix_seen[14358], 1);
        check("s1_box_model", box_mismatches(), 0);
        check("s1_done", done_cnt, 1);
        check("s1_busy_end", busy, 0);
        check("s1_we_end", we, 0);
        check("s1_count", frame_count, 1);
        tick();
        check("s1_done_pulse", frame_done, 0);

        // Same frame under random back-pressure around both ends of the frame
        for (int a = 0; a < 19200; a++) pix_seen[a] = 1'bx;
        start_frame();
        capture(3000, 40000, -1);
        check("s2_accepted", accepted, 19200);
        check("s2_order", order_err, 0);
        check("s2_stall_stable", stall_err, 0);
        check("s2_box_model", box_mismatches(), 0);
        check("s2_done", done_cnt, 1);
        check("s2_count", frame_count, 2);

        // Checker cells, then an asynchronous reset mid-frame
        mode = 3'd2; fg = 1'b1; bg = 1'b0;
        start_frame();
        capture(0, 6000, 5000);
        check("s3_reach_5000", write_addr, 5000);
        check("s3_pix0", pix_seen[0], 0);
        check("s3_pix8", pix_seen[8], 1);
        check("s3_pix1280", pix_seen[1280], 1);
        check("s3_pix1288", pix_seen[1288], 0);
        reset_n = 1'b0;
        #2;
        check("s5_async_we", we, 0);
        check("s5_async_busy", busy, 0);
        check("s5_async_addr", write_addr, 0);
        tick();
        reset_n = 1'b1;
        tick();
        start_frame();
        check("s5_restart_we", we, 1);
        check("s5_restart_addr", write_addr, 0);
        tick();
        check("s5_restart_next", write_addr, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Continuous frames: solid, then border picked up at the frame boundary
        mode = 3'd0; fg = 1'b1; bg = 1'b0; continuous = 1'b1; wr_ready = 1'b1;
        start_frame();
        idx = 0; frame = 1; bad1 = 0; fgcnt = 0; order_err = 0; done_cnt = 0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            start = 1'b0;
            if (frame_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    check("s4_nobubble_we", we, 1);
                    check("s4_nobubble_addr", write_addr, 0);
                    check("s4_frame1_len", idx, 19200);
                    continuous = 1'b0;
                    frame = 2;
                    idx = 0;
                end else begin
                    break;
                end
            end
            if (we && wr_ready) begin
                if (int'(write_addr) != idx) order_err++;
                if (frame == 1 && pixel !== 1'b1) bad1++;
                if (frame == 2) begin
                    pix_seen[write_addr] = pixel;
                    if (pixel === 1'b1) fgcnt++;
                end
                idx++;
            end
            if (frame == 1 && idx == 9000) begin
                mode  = 3'd4;
                start = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        check("s4_frame1_solid", bad1, 0);
        check("s4_order", order_err, 0);
        check("s4_frame2_len", idx, 19200);
        check("s4_pix161", pix_seen[161], 0);
        check("s4_pix160", pix_seen[160], 1);
        check("s4_border_fg", fgcnt, 556);
        check("s4_done", done_cnt, 2);
        check("s4_idle_we", we, 0);
        check("s4_idle_busy", busy, 0);
        check("s4_count", frame_count, 2);

        // Overridden 4x3 geometry, border pattern
        mode = 3'd4; fg = 1'b1; bg = 1'b0; continuous = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        mask = '0; last_acc = -1; s_acc = 0; s_seen = 1'b0; order_err = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (s_done) begin
                s_seen = 1'b1;
                break;
            end
            if (s_we && s_ready) begin
                if (int'(s_addr) != s_acc) order_err++;
                mask[s_addr] = s_pixel;
                last_acc = int'(s_addr);
                s_acc++;
            end
            tick();
        end
        check("s6_done_seen", s_seen, 1);
        check("s6_last_addr", last_acc, 11);
        check("s6_accepted", s_acc, 12);
        check("s6_order", order_err, 0);
        check("s6_mask", mask, 12'hF9F);
        check("s6_we_end", s_we, 0);
        check("s6_busy_end", s_busy, 0);
        check("s6_count", s_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
